// File: rtl/l1_l2_arbiter.sv
// Two-master round-robin arbiter between the L1 I-cache and L1 D-cache,
// holding one latched line request toward the unified L2 at a time.
//
//  state  | meaning
//  IDLE   | no request outstanding; a grant is made on this cycle's edge
//  I_BUSY | captured I-cache read driven to L2 until l2_resp
//  D_BUSY | captured D-cache read/write driven to L2 until l2_resp
//  DONE   | one bubble cycle so the completing master can drop its request

module l1_l2_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  i_mem_address,
   input  logic         i_mem_read,
   output logic [255:0] i_mem_rdata,
   output logic         i_mem_resp,
   input  logic [31:0]  d_mem_address,
   input  logic [255:0] d_mem_wdata,
   input  logic         d_mem_read,
   input  logic         d_mem_write,
   output logic [255:0] d_mem_rdata,
   output logic         d_mem_resp,
   output logic [31:0]  l2_address,
   output logic [255:0] l2_wdata,
   output logic         l2_read,
   output logic         l2_write,
   input  logic [255:0] l2_rdata,
   input  logic         l2_resp
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

   state_t state;
   logic   last_grant;
   logic   i_req;
   logic   d_req;
   logic   grant_d;

   assign i_req   = i_mem_read;
   assign d_req   = d_mem_read | d_mem_write;
   // On contention the master that did not win last time goes first.
   assign grant_d = d_req & (~i_req | ~last_grant);

   assign i_mem_resp  = l2_resp & (state == I_BUSY);
   assign d_mem_resp  = l2_resp & (state == D_BUSY);
   assign i_mem_rdata = l2_rdata;
   assign d_mem_rdata = l2_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         l2_read    <= 1'b0;
         l2_write   <= 1'b0;
         l2_address <= '0;
         l2_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state      <= D_BUSY;
                  last_grant <= 1'b1;
                  l2_address <= d_mem_address;
                  l2_wdata   <= d_mem_wdata;
                  // read+write together is illegal; it is served as a write
                  l2_write   <= d_mem_write;
                  l2_read    <= ~d_mem_write;
               end else if (i_req) begin
                  state      <= I_BUSY;
                  last_grant <= 1'b0;
                  l2_address <= i_mem_address;
                  l2_wdata   <= '0;
                  l2_write   <= 1'b0;
                  l2_read    <= 1'b1;
               end
            end
            I_BUSY, D_BUSY: begin
               if (l2_resp) begin
                  state    <= DONE;
                  l2_read  <= 1'b0;
                  l2_write <= 1'b0;
               end
            end
            DONE: state <= IDLE;
            default: begin
               state    <= IDLE;
               l2_read  <= 1'b0;
               l2_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Randomized scoreboard bench for l1_l2_arbiter: expected L2 requests come
// from a round-robin order model, expected master responses from an L2 model.

module tb_l1_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  i_mem_address;
   logic         i_mem_read;
   logic [255:0] i_mem_rdata;
   logic         i_mem_resp;
   logic [31:0]  d_mem_address;
   logic [255:0] d_mem_wdata;
   logic         d_mem_read;
   logic         d_mem_write;
   logic [255:0] d_mem_rdata;
   logic         d_mem_resp;
   logic [31:0]  l2_address;
   logic [255:0] l2_wdata;
   logic         l2_read;
   logic         l2_write;
   logic [255:0] l2_rdata;
   logic         l2_resp;

   l1_l2_arbiter dut (
      .clk(clk), .rst(rst),
      .i_mem_address(i_mem_address), .i_mem_read(i_mem_read),
      .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
      .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
      .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_read(l2_read), .l2_write(l2_write),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         master;   // 0 = I, 1 = D
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic         first;    // first grant of a batch
   } req_t;

   typedef struct packed {
      logic         master;
      logic [255:0] data;
   } rsp_t;

   req_t exp_q[$];
   rsp_t resp_q[$];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   req_cyc;
   int   last_resp_cyc;
   bit   l2_en = 0;
   bit   i_done, d_done, i_started, d_started;
   bit   model_last = 0;
   bit   force_en = 0;
   logic [255:0] force_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom();
      return v;
   endfunction

   // L2 model: accepts each new strobe, checks it against the expected
   // grant order, answers after a random latency, may fire stray l2_resp.
   initial begin
      req_t         cur;
      rsp_t         r;
      int           cnt;
      bit           busy = 0;
      bit           done_ph = 0;
      logic [255:0] rd;
      l2_resp  = 1'b0;
      l2_rdata = '0;
      cnt      = 0;
      cur      = '0;
      forever begin
         @(posedge clk); #1;
         l2_resp = 1'b0;
         if (!l2_en) begin
            busy = 0;
            done_ph = 0;
            continue;
         end
         if (done_ph) begin
            chk("strobe_drop", 256'({l2_read, l2_write}), 256'(0));
            done_ph = 0;
         end else if (!busy && (l2_read || l2_write)) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_l2_req: rd=%0b wr=%0b addr=%h want no request", l2_read, l2_write, l2_address);
            end else begin
               cur  = exp_q.pop_front();
               busy = 1;
               cnt  = $urandom_range(0, 5);
               if (cur.first) chk("grant_latency", 256'(cyc), 256'(req_cyc + 1));
               else           chk("regrant_latency", 256'(cyc), 256'(last_resp_cyc + 3));
               if (cur.master) d_started = 1; else i_started = 1;
            end
         end
         if (busy) begin
            chk("l2_read",    256'(l2_read),    256'(!cur.wr));
            chk("l2_write",   256'(l2_write),   256'(cur.wr));
            chk("l2_address", 256'(l2_address), 256'(cur.addr));
            chk("l2_wdata",   l2_wdata,         cur.wdata);
            if (cnt == 0) begin
               rd = force_en ? force_data : rand256();
               l2_rdata = rd;
               l2_resp  = 1'b1;
               r.master = cur.master;
               r.data   = rd;
               resp_q.push_back(r);
               busy = 0;
               done_ph = 1;
               last_resp_cyc = cyc;
            end else begin
               cnt--;
            end
         end else if ($urandom_range(0, 4) == 0) begin
            l2_rdata = rand256();
            l2_resp  = 1'b1;
         end
      end
   end

   // Response monitor: every master resp must match the next L2 answer.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (i_mem_resp || d_mem_resp) begin
            if (resp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL stray_resp: i_resp=%0b d_resp=%0b want none", i_mem_resp, d_mem_resp);
            end else begin
               r = resp_q.pop_front();
               chk("resp_d", 256'(d_mem_resp), 256'(r.master));
               chk("resp_i", 256'(i_mem_resp), 256'(!r.master));
               chk("resp_data", r.master ? d_mem_rdata : i_mem_rdata, r.data);
               if (r.master) d_done = 1; else i_done = 1;
            end
         end
      end
   end

   task automatic batch(input bit use_i, input bit use_d, input bit d_rd, input bit d_wr,
                        input logic [31:0] ia, input logic [31:0] da, input logic [255:0] dw);
      req_t ei, ed;
      int   budget;
      ei.master = 1'b0; ei.wr = 1'b0; ei.addr = ia; ei.wdata = '0; ei.first = 1'b1;
      ed.master = 1'b1; ed.wr = d_wr; ed.addr = da; ed.wdata = dw; ed.first = 1'b1;
      @(posedge clk); #1;
      if (use_i && use_d) begin
         // Contention: the one that did not win last goes first, then the other.
         if (!model_last) begin ei.first = 1'b0; exp_q.push_back(ed); exp_q.push_back(ei); model_last = 0; end
         else             begin ed.first = 1'b0; exp_q.push_back(ei); exp_q.push_back(ed); model_last = 1; end
      end else if (use_i) begin
         exp_q.push_back(ei); model_last = 0;
      end else begin
         exp_q.push_back(ed); model_last = 1;
      end
      i_done = 0; d_done = 0; i_started = 0; d_started = 0;
      req_cyc = cyc;
      if (use_i) begin i_mem_address = ia; i_mem_read = 1'b1; end
      if (use_d) begin d_mem_address = da; d_mem_wdata = dw; d_mem_read = d_rd; d_mem_write = d_wr; end
      budget = 0;
      while (i_mem_read || d_mem_read || d_mem_write) begin
         @(posedge clk); #1;
         budget++;
         if (i_done) i_mem_read = 1'b0;
         else if (i_started) i_mem_address = $urandom();
         if (d_done) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
         else if (d_started) begin d_mem_address = $urandom(); d_mem_wdata = rand256(); end
         if (budget > 100) begin
            total++; bad++;
            $display("FAIL batch_timeout: i_done=%0b d_done=%0b want both served within 100 cycles", i_done, d_done);
            i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
         end
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
   endtask

   initial begin
      int op;
      rst = 1'b1;
      i_mem_address = '0; i_mem_read = 1'b0;
      d_mem_address = '0; d_mem_wdata = '0; d_mem_read = 1'b0; d_mem_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_l2_read",    256'(l2_read),    256'(0));
      chk("rst_l2_write",   256'(l2_write),   256'(0));
      chk("rst_l2_address", 256'(l2_address), 256'(0));
      chk("rst_l2_wdata",   l2_wdata,         256'(0));
      chk("rst_i_resp",     256'(i_mem_resp), 256'(0));
      chk("rst_d_resp",     256'(d_mem_resp), 256'(0));
      rst = 1'b0;

      // Reset in the third D_BUSY cycle abandons the transaction.
      d_mem_address = 32'h0000_4080; d_mem_wdata = rand256(); d_mem_write = 1'b1;
      @(posedge clk); #1;
      chk("mid_grant_write", 256'(l2_write),   256'(1));
      chk("mid_grant_addr",  256'(l2_address), 256'(32'h0000_4080));
      repeat (2) @(posedge clk);
      #1;
      chk("mid_busy_write", 256'(l2_write), 256'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_strobes", 256'({l2_read, l2_write}), 256'(0));
      chk("mid_rst_resps",   256'({i_mem_resp, d_mem_resp}), 256'(0));
      rst = 1'b0;
      d_mem_write = 1'b0;
      model_last = 0;
      l2_en = 1;
      @(posedge clk);

      force_en = 1; force_data = {32{8'hA5}};
      batch(1, 0, 0, 0, 32'h0000_1000, 32'h0, '0);
      force_en = 0;
      batch(0, 1, 0, 1, 32'h0, 32'h0000_2040, {8{32'h1234_5678}});
      batch(1, 1, 1, 0, 32'h0000_5000, 32'h0000_6000, rand256());
      batch(1, 1, 0, 1, 32'h0000_5040, 32'h0000_6040, rand256());
      batch(0, 1, 1, 1, 32'h0, 32'h0000_3000, rand256());

      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 2);
         case ($urandom_range(0, 2))
            0:       batch(1, 0, 0, 0, $urandom(), 32'h0, '0);
            1:       batch(0, 1, op != 1, op != 0, 32'h0, $urandom(), rand256());
            default: batch(1, 1, op != 1, op != 0, $urandom(), $urandom(), rand256());
         endcase
      end

      repeat (5) @(posedge clk);
      #1;
      chk("exp_q_drained",  256'(exp_q.size()),  256'(0));
      chk("resp_q_drained", 256'(resp_q.size()), 256'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
